rv32i_multicycle_ctrl: RTL

Multi-cycle control sequencer for the RV32I datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives the enables and selects for the PC register, instruction register, memory port, ALU operand muxes, register-file write and write-back mux. It classifies the opcode from the instruction register, the same 7-bit field the immediate generator decodes. It handshakes with a single shared instruction/data memory port that may insert wait states.

---
 rtl/rv32i_pkg.sv | 52 +++++
 rtl/rv32i_op_class.sv | 29 ++
 rtl/rv32i_multicycle_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, control FSM states, PC/write-back mux encodings, op classes.
// Pure declarations; no latency or backpressure of its own.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_t;

    // One-hot; all-zero means the opcode is not supported.
    typedef struct packed {
        logic op;
        logic op_imm;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } op_class_t;

endpackage

// File: rtl/rv32i_op_class.sv
// Opcode classifier: instr[6:0] to one-hot class plus illegal flag; purely combinational,
// zero latency, no flow control.
module rv32i_op_class
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP:     cls.op     = 1'b1;
            OPC_OP_IMM: cls.op_imm = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL:    cls.jal    = 1'b1;
            OPC_JALR:   cls.jalr   = 1'b1;
            OPC_LUI:    cls.lui    = 1'b1;
            OPC_AUIPC:  cls.auipc  = 1'b1;
            default:    cls        = '0;
        endcase
    end

    assign illegal = ~|cls;

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: 3 (branch), 4 (ALU/jump/store) or 5 (load) cycles per instruction;
// memory wait states stretch FETCH/MEM with mem_req held, and reset kills any request in flight.
module rv32i_multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] reset_pc,
    output logic [31:0] retired,
    output logic        illegal
);

    state_t    state;
    state_t    state_nx;
    op_class_t cls;
    logic      cls_illegal;
    logic      unused_instr_bits;

    assign unused_instr_bits = ^instr[31:7];

    rv32i_op_class u_op_class (
        .opcode  (instr[6:0]),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (pc_we) begin
            retired <= retired + 32'd1;
        end
    end

    // Every strobe is forced low while rst_n is asserted, whatever the state register holds.
    always_comb begin
        state_nx     = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;

        // Operand selects stay valid through MEM/WB so the ALU result feeding the address or write-back holds.
        if (state == EXEC || state == MEM || state == WB) begin
            alu_a_sel = cls.auipc | cls.jal | cls.branch;
            alu_b_sel = cls.op_imm | cls.load | cls.store | cls.jalr | cls.auipc;
        end

        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we    = 1'b1;
                        state_nx = DECODE;
                    end
                end
                DECODE: begin
                    state_nx = cls_illegal ? TRAP : EXEC;
                end
                EXEC: begin
                    if (cls.branch) begin
                        pc_we    = 1'b1;
                        pc_sel   = branch_taken ? PC_IMM : PC_PLUS4;
                        state_nx = FETCH;
                    end else if (cls.load || cls.store) begin
                        state_nx = MEM;
                    end else begin
                        state_nx = WB;
                    end
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = cls.store;
                    if (mem_ready) begin
                        if (cls.store) begin
                            pc_we    = 1'b1;
                            state_nx = FETCH;
                        end else begin
                            state_nx = WB;
                        end
                    end
                end
                WB: begin
                    rf_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = FETCH;
                    if (cls.load) begin
                        wb_sel = WB_LOAD;
                    end else if (cls.jal || cls.jalr) begin
                        wb_sel = WB_PC4;
                    end else if (cls.lui) begin
                        wb_sel = WB_IMM;
                    end
                    if (cls.jal) begin
                        pc_sel = PC_IMM;
                    end else if (cls.jalr) begin
                        pc_sel = PC_ALU;
                    end
                end
                TRAP: begin
                    state_nx = TRAP;
                end
                default: begin
                    state_nx = FETCH;
                end
            endcase
        end
    end

    assign illegal  = (state == TRAP);
    assign reset_pc = RESET_PC;

endmodule
